comparador_sequencial: RTL and testbench

- Multi-cycle controller that compares two wide unsigned operands by reusing a single external 4-bit magnitude comparator, one nibble per cycle from the MSB down.
- Latches operands on a start request, feeds nibbles to the comparator, samples its eq/gt/lt outputs, and reports a registered three-way result with a one-cycle done pulse.
- Sits between a requester, such as a sort/min-max unit, and the shared 4-bit comparator datapath.

---
 rtl/comparador_sequencial_if.sv | 35 +++
 rtl/comparador_sequencial.sv | 133 +++++++++++++
 tb/tb_comparador_sequencial.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_sequencial_if.sv
// Bundle between a requester, the sequential comparator controller and the
// shared 4-bit magnitude comparator it borrows one nibble per cycle.
interface comparador_sequencial_if #(
  parameter int NIBBLES = 4
);
  // Handshake: start is a request that the controller accepts only while idle
  // (busy=0 and done=0). Requests seen in any other cycle are dropped, not
  // queued. Operands are captured on the accepting edge. Each accepted request
  // produces exactly one single-cycle done pulse with aeqb/agtb/altb valid from
  // that cycle until the next completion.
  logic                   start;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   busy;
  logic                   done;
  logic                   aeqb;
  logic                   agtb;
  logic                   altb;
  logic                   cmp_err;
  logic [3:0]             cmp_a;
  logic [3:0]             cmp_b;
  logic                   cmp_eq;
  logic                   cmp_gt;
  logic                   cmp_lt;

  modport master (
    output start, a, b, cmp_eq, cmp_gt, cmp_lt,
    input  busy, done, aeqb, agtb, altb, cmp_err, cmp_a, cmp_b
  );

  modport slave (
    input  start, a, b, cmp_eq, cmp_gt, cmp_lt,
    output busy, done, aeqb, agtb, altb, cmp_err, cmp_a, cmp_b
  );
endinterface

// File: rtl/comparador_sequencial.sv
// Compares two wide unsigned operands MSB-first by reusing one external 4-bit
// comparator; returns a registered one-hot result with a single-cycle done.
module comparador_sequencial #(
  parameter int NIBBLES    = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  comparador_sequencial_if.slave bus,
  output logic [1:0]             state_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            decided_q;
  logic            dec_gt_q;
  logic            busy_q;
  logic            done_q;
  logic            aeqb_q;
  logic            agtb_q;
  logic            altb_q;
  logic            cmp_err_q;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic            s_eq;
  logic            s_gt;
  logic            one_hot;
  logic            last_step;
  logic            fin_dec;
  logic            fin_gt;

  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // A malformed sample resolves with priority eq > gt > lt, so all-zero reads as lt.
  always_comb begin
    s_eq      = bus.cmp_eq;
    s_gt      = !bus.cmp_eq && bus.cmp_gt;
    one_hot   = ({1'b0, bus.cmp_eq} + {1'b0, bus.cmp_gt} + {1'b0, bus.cmp_lt}) == 2'd1;
    last_step = ((EARLY_EXIT != 0) && !s_eq) || (idx_q == '0);
    fin_dec   = decided_q || !s_eq;
    fin_gt    = decided_q ? dec_gt_q : s_gt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aeqb_q    <= 1'b0;
      agtb_q    <= 1'b0;
      altb_q    <= 1'b0;
      cmp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            idx_q     <= IW'(NIBBLES - 1);
            cmp_err_q <= 1'b0;
            decided_q <= 1'b0;
            dec_gt_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= COMPARE;
          end
        end
        COMPARE: begin
          if (!one_hot) cmp_err_q <= 1'b1;
          // Only the most significant differing nibble decides the outcome.
          if (!decided_q && !s_eq) begin
            decided_q <= 1'b1;
            dec_gt_q  <= s_gt;
          end
          if (last_step) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            aeqb_q  <= !fin_dec;
            agtb_q  <= fin_dec && fin_gt;
            altb_q  <= fin_dec && !fin_gt;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmp_a   = (state_q == COMPARE) ? nib_a : 4'd0;
  assign bus.cmp_b   = (state_q == COMPARE) ? nib_b : 4'd0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aeqb    = aeqb_q;
  assign bus.agtb    = agtb_q;
  assign bus.altb    = altb_q;
  assign bus.cmp_err = cmp_err_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_comparador_sequencial.sv
// Bench for comparador_sequencial: one early-exit and one full-scan instance
// share stimulus; a behavioural nibble comparator and reference model check them.
module tb_comparador_sequencial;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        start_r = 1'b0;
  logic [W-1:0] a_r = '0;
  logic [W-1:0] b_r = '0;
  logic        force_r = 1'b0;
  logic [1:0]  st0;
  logic [1:0]  st1;

  comparador_sequencial_if #(.NIBBLES(N)) if0 ();
  comparador_sequencial_if #(.NIBBLES(N)) if1 ();

  comparador_sequencial #(.NIBBLES(N), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .state_o(st0));
  comparador_sequencial #(.NIBBLES(N), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .state_o(st1));

  assign if0.start  = start_r && (sel == 0);
  assign if1.start  = start_r && (sel == 1);
  assign if0.a = a_r;
  assign if0.b = b_r;
  assign if1.a = a_r;
  assign if1.b = b_r;
  // Behavioural 4-bit comparators; force_r injects an eq+gt fault.
  assign if0.cmp_eq = (if0.cmp_a == if0.cmp_b) || (force_r && sel == 0);
  assign if0.cmp_gt = (if0.cmp_a >  if0.cmp_b) || (force_r && sel == 0);
  assign if0.cmp_lt = (if0.cmp_a <  if0.cmp_b);
  assign if1.cmp_eq = (if1.cmp_a == if1.cmp_b) || (force_r && sel == 1);
  assign if1.cmp_gt = (if1.cmp_a >  if1.cmp_b) || (force_r && sel == 1);
  assign if1.cmp_lt = (if1.cmp_a <  if1.cmp_b);

  logic       busy_s, done_s, err_s;
  logic [2:0] res_s;
  logic [3:0] cmpa_s;
  assign busy_s = (sel == 1) ? if1.busy : if0.busy;
  assign done_s = (sel == 1) ? if1.done : if0.done;
  assign err_s  = (sel == 1) ? if1.cmp_err : if0.cmp_err;
  assign res_s  = (sel == 1) ? {if1.aeqb, if1.agtb, if1.altb} : {if0.aeqb, if0.agtb, if0.altb};
  assign cmpa_s = (sel == 1) ? if1.cmp_a : if0.cmp_a;

  int checks = 0;
  int errors = 0;

  int         obs_lat;
  logic [2:0] obs_res;
  logic       obs_err;
  logic [3:0] trace_q[$];

  // Compare cycles used: full scan, or up to the highest differing nibble.
  function automatic int ref_c(input logic [W-1:0] x, input logic [W-1:0] y, input int ee);
    if (ee == 0) return N;
    for (int i = N - 1; i >= 0; i--)
      if (x[4*i +: 4] != y[4*i +: 4]) return N - i;
    return N;
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // Issue one request, record cmp_a each busy cycle and the done-cycle results.
  task automatic do_op(input int s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int fault_k);
    sel = s;
    trace_q.delete();
    obs_lat = -1;
    obs_res = 3'b000;
    obs_err = 1'b0;
    @(negedge clk);
    a_r = av; b_r = bv; start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    a_r = W'($urandom);
    b_r = W'($urandom);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy_s) trace_q.push_back(cmpa_s);
      force_r = busy_s && (n == fault_k);
      if (done_s) begin
        obs_lat = n;
        obs_res = res_s;
        obs_err = err_s;
        break;
      end
    end
    force_r = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({if0.busy, if0.done, if0.aeqb, if0.agtb, if0.altb, if0.cmp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut0 got %b want 000000",
               {if0.busy, if0.done, if0.aeqb, if0.agtb, if0.altb, if0.cmp_err});
    end
    checks++;
    if ({if1.busy, if1.done, if1.aeqb, if1.agtb, if1.altb, if1.cmp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut1 got %b want 000000",
               {if1.busy, if1.done, if1.aeqb, if1.agtb, if1.altb, if1.cmp_err});
    end
    checks++;
    if (if0.cmp_a !== 4'h0 || if0.cmp_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_cmp_bus got %h/%h want 0/0", if0.cmp_a, if0.cmp_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_equal;
    logic [3:0] exp_q[$];
    exp_q = '{4'hB, 4'hE, 4'hE, 4'hF};
    do_op(0, 16'hBEEF, 16'hBEEF, 0);
    checks++;
    if (obs_lat !== 5) begin
      errors++; $display("FAIL equal_latency got %0d want 5", obs_lat);
    end
    checks++;
    if (obs_res !== 3'b100) begin
      errors++; $display("FAIL equal_result got %b want 100", obs_res);
    end
    checks++;
    if (trace_q.size() != exp_q.size()) begin
      errors++; $display("FAIL equal_trace_len got %0d want %0d", trace_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (trace_q[j] !== exp_q[j]) begin
          errors++; $display("FAIL equal_trace[%0d] got %h want %h", j, trace_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_early_lt;
    do_op(0, 16'h1234, 16'h1243, 0);
    checks++;
    if (obs_lat !== 4) begin
      errors++; $display("FAIL early_lt_latency got %0d want 4", obs_lat);
    end
    checks++;
    if (obs_res !== 3'b001) begin
      errors++; $display("FAIL early_lt_result got %b want 001", obs_res);
    end
    checks++;
    if (trace_q.size() != 3) begin
      errors++; $display("FAIL early_lt_trace_len got %0d want 3", trace_q.size());
    end
  endtask

  task automatic test_full_gt;
    do_op(1, 16'h9000, 16'h8FFF, 0);
    checks++;
    if (obs_lat !== 5) begin
      errors++; $display("FAIL full_gt_latency got %0d want 5", obs_lat);
    end
    checks++;
    if (obs_res !== 3'b010) begin
      errors++; $display("FAIL full_gt_result got %b want 010", obs_res);
    end
    checks++;
    if (trace_q.size() != 4) begin
      errors++; $display("FAIL full_gt_trace_len got %0d want 4", trace_q.size());
    end
  endtask

  task automatic test_reset_mid;
    sel = 0;
    @(negedge clk);
    a_r = 16'h1234; b_r = 16'h1243; start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if0.busy, if0.done, if0.aeqb, if0.agtb, if0.altb, if0.cmp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b want 000000",
               {if0.busy, if0.done, if0.aeqb, if0.agtb, if0.altb, if0.cmp_err});
    end
    checks++;
    if (if0.cmp_a !== 4'h0) begin
      errors++; $display("FAIL reset_mid_cmp_a got %h want 0", if0.cmp_a);
    end
    do_op(0, 16'h7000, 16'h6FFF, 0);
    checks++;
    if (obs_lat !== 2 || obs_res !== 3'b010) begin
      errors++; $display("FAIL reset_mid_after got lat %0d res %b want lat 2 res 010", obs_lat, obs_res);
    end
  endtask

  task automatic test_fault;
    do_op(0, 16'h0000, 16'h0000, 2);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++; $display("FAIL fault_err got %b want 1", obs_err);
    end
    checks++;
    if (obs_res !== 3'b100 || obs_lat !== 5) begin
      errors++; $display("FAIL fault_result got res %b lat %0d want res 100 lat 5", obs_res, obs_lat);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (if0.cmp_err !== 1'b1) begin
      errors++; $display("FAIL fault_sticky got %b want 1", if0.cmp_err);
    end
    do_op(0, 16'h5555, 16'h5555, 0);
    checks++;
    if (obs_err !== 1'b0 || obs_res !== 3'b100) begin
      errors++; $display("FAIL fault_clear got err %b res %b want err 0 res 100", obs_err, obs_res);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] pa[4];
    logic [W-1:0] pb[4];
    int k, last, cyc, gap;
    pa = '{16'h1234, 16'hBEEF, 16'h9000, 16'h0F0F};
    pb = '{16'h1243, 16'hBEEF, 16'h1000, 16'h0F0E};
    sel = 0;
    k = 0; last = 0; cyc = 0;
    @(negedge clk);
    a_r = pa[0]; b_r = pb[0]; start_r = 1'b1;
    @(posedge clk);
    while (k < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (if0.done) begin
        gap = ref_c(pa[k], pb[k], 1) + ((k == 0) ? 1 : 2);
        checks++;
        if (cyc - last != gap) begin
          errors++; $display("FAIL b2b_period[%0d] got %0d want %0d", k, cyc - last, gap);
        end
        checks++;
        if ({if0.aeqb, if0.agtb, if0.altb} !== ref_res(pa[k], pb[k])) begin
          errors++; $display("FAIL b2b_result[%0d] got %b want %b", k,
                             {if0.aeqb, if0.agtb, if0.altb}, ref_res(pa[k], pb[k]));
        end
        last = cyc;
        k++;
        if (k < 4) begin
          a_r = pa[k]; b_r = pb[k];
        end
      end else if (if0.busy) begin
        a_r = W'($urandom);
        b_r = W'($urandom);
      end
    end
    start_r = 1'b0;
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL b2b_timeout got %0d done pulses want 4", k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    int s, c;
    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(0, 1);
      x = W'($urandom);
      y = x;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) y[4*i +: 4] = 4'($urandom);
      do_op(s, x, y, 0);
      c = ref_c(x, y, (s == 0) ? 1 : 0);
      checks++;
      if (obs_lat != c + 1 || obs_res !== ref_res(x, y) || obs_err !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h dut%0d got lat %0d res %b err %b want lat %0d res %b err 0",
                 it, x, y, s, obs_lat, obs_res, obs_err, c + 1, ref_res(x, y));
      end
      checks++;
      if (trace_q.size() != c) begin
        errors++; $display("FAIL random_trace_len[%0d] got %0d want %0d", it, trace_q.size(), c);
      end else begin
        for (int j = 0; j < c; j++) begin
          checks++;
          if (trace_q[j] !== x[4*(N-1-j) +: 4]) begin
            errors++; $display("FAIL random_trace[%0d][%0d] got %h want %h",
                               it, j, trace_q[j], x[4*(N-1-j) +: 4]);
          end
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset;
    test_equal;
    test_early_lt;
    test_full_gt;
    test_reset_mid;
    test_fault;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
